// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer, plus a parameter-range
// check that the top evaluates at elaboration.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN,
        FORCE
    } state_t;

    localparam int LOCK_CNT_W = 8;

    function automatic bit params_ok(int nb_stages, int stage_delay,
                                     int lock_filter, int sw_rst_min);
        return (nb_stages >= 1) && (nb_stages <= 8) && (stage_delay >= 1) &&
               (lock_filter >= 1) && (sw_rst_min >= 1);
    endfunction

endpackage

// File: rtl/rst_seq_sync2.sv
// Generic two-flop level synchronizer with async active-low reset to 0.
module sync2 (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: qualifies PLL lock, releases per-domain resets in a staggered
// ascending order, and re-asserts them all together on lock loss or sw_rst.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NB_STAGES   = 3,
    parameter int STAGE_DELAY = 16,
    parameter int LOCK_FILTER = 8,
    parameter int SW_RST_MIN  = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  pll_locked,
    input  logic                  sw_rst,
    output logic [NB_STAGES-1:0]  stage_nrst,
    output logic                  ready,
    output logic [LOCK_CNT_W-1:0] lock_lost_cnt
);

    localparam int CNT_W  = $clog2(NB_STAGES * STAGE_DELAY + 1);
    localparam int FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int FCNT_W = (SW_RST_MIN > 1) ? $clog2(SW_RST_MIN) : 1;

    if (!params_ok(NB_STAGES, STAGE_DELAY, LOCK_FILTER, SW_RST_MIN)) begin : g_bad_params
        $error("rst_seq: parameter out of legal range");
    end

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FILT_W-1:0]      filt_q, filt_d;
    logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
    logic [NB_STAGES-1:0]   stage_q, stage_d;
    logic                   ready_q, ready_d;
    logic [LOCK_CNT_W-1:0]  llc_q, llc_d;
    logic                   lk;
    logic                   lost;

    sync2 u_lock_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (pll_locked),
        .q    (lk)
    );

    assign lost = ((state_q == RELEASE) || (state_q == RUN)) && !lk;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        filt_d  = filt_q;
        fcnt_d  = fcnt_q;
        stage_d = stage_q;
        ready_d = ready_q;
        llc_d   = llc_q;

        // Lock loss is counted even when a simultaneous sw_rst takes priority.
        if (lost && (llc_q != '1)) llc_d = llc_q + 1'b1;

        if (sw_rst) begin
            state_d = FORCE;
            fcnt_d  = FCNT_W'(SW_RST_MIN - 1);
            stage_d = '0;
            ready_d = 1'b0;
            filt_d  = '0;
            cnt_d   = '0;
        end else if (lost) begin
            state_d = HOLD;
            stage_d = '0;
            ready_d = 1'b0;
            filt_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    stage_d = '0;
                    ready_d = 1'b0;
                    if (!lk) begin
                        filt_d = '0;
                    end else if (filt_q == FILT_W'(LOCK_FILTER - 1)) begin
                        state_d = RELEASE;
                        filt_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        filt_d = filt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    cnt_d = cnt_q + 1'b1;
                    for (int i = 0; i < NB_STAGES; i++) begin
                        if (cnt_d == CNT_W'((i + 1) * STAGE_DELAY)) stage_d[i] = 1'b1;
                    end
                    if (cnt_d == CNT_W'(NB_STAGES * STAGE_DELAY)) state_d = RUN;
                end
                RUN: begin
                    stage_d = '1;
                    ready_d = 1'b1;
                end
                FORCE: begin
                    stage_d = '0;
                    ready_d = 1'b0;
                    if (fcnt_q == '0) begin
                        state_d = HOLD;
                        filt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q - 1'b1;
                    end
                end
                default: state_d = HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            filt_q  <= '0;
            fcnt_q  <= '0;
            stage_q <= '0;
            ready_q <= 1'b0;
            llc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            fcnt_q  <= fcnt_d;
            stage_q <= stage_d;
            ready_q <= ready_d;
            llc_q   <= llc_d;
        end
    end

    assign stage_nrst    = stage_q;
    assign ready         = ready_q;
    assign lock_lost_cnt = llc_q;

endmodule

// File: tb/tb_rst_seq.sv
// Randomized scoreboard bench for rst_seq: a timeline model predicts outputs
// every cycle, a monitor compares them on the falling edge.
module tb_rst_seq;
    localparam int NB = 3, SD = 16, LF = 8, SM = 4;

    logic clk = 1'b0, nrst = 1'b0, pll_locked = 1'b0, sw_rst = 1'b0;
    logic [NB-1:0] stage_nrst;
    logic          ready;
    logic [7:0]    lock_lost_cnt;

    rst_seq #(.NB_STAGES(NB), .STAGE_DELAY(SD), .LOCK_FILTER(LF), .SW_RST_MIN(SM)) dut (
        .clk(clk), .nrst(nrst), .pll_locked(pll_locked), .sw_rst(sw_rst),
        .stage_nrst(stage_nrst), .ready(ready), .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    typedef logic [NB+8:0] obs_t;
    obs_t exp_q[$];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Model: m_rel = cycles since release began (-1 = not releasing),
    // m_run = consecutive locked cycles seen while waiting, m_force = in sw hold.
    bit m_s1, m_s2, m_force;
    int m_run, m_rel, m_fleft, m_llc;

    function automatic obs_t model_out();
        obs_t o = '0;
        o[7:0] = m_llc[7:0];
        if (!m_force && m_rel >= 0) begin
            for (int i = 0; i < NB; i++) o[9+i] = (m_rel >= (i + 1) * SD);
            o[8] = (m_rel >= NB * SD + 1);
        end
        return o;
    endfunction

    always @(posedge clk) begin
        bit lk, lost;
        if (!nrst) begin
            m_s1 = 0; m_s2 = 0; m_force = 0;
            m_run = 0; m_rel = -1; m_fleft = 0; m_llc = 0;
        end else begin
            lk   = m_s2;
            lost = !m_force && (m_rel >= 0) && !lk;
            m_s2 = m_s1;
            m_s1 = pll_locked;
            if (lost && m_llc < 255) m_llc++;
            if (sw_rst) begin
                m_force = 1; m_fleft = SM - 1; m_rel = -1; m_run = 0;
            end else if (m_force) begin
                if (m_fleft == 0) begin m_force = 0; m_run = 0; end
                else m_fleft--;
            end else if (lost) begin
                m_rel = -1; m_run = 0;
            end else if (m_rel >= 0) begin
                m_rel++;
            end else if (lk) begin
                m_run++;
                if (m_run == LF) begin m_rel = 0; m_run = 0; end
            end else begin
                m_run = 0;
            end
        end
        exp_q.push_back(model_out());
    end

    always @(negedge clk) begin
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs", 32'({stage_nrst, ready, lock_lost_cnt}), 32'(e));
        end
    end

    task automatic cyc(int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    initial begin
        int k;
        // Power-up with lock present from the start
        nrst = 0; pll_locked = 1; cyc(5);
        nrst = 1; cyc(75);
        // Lock loss, glitchy relock, then steady
        pll_locked = 0; cyc(5);
        pll_locked = 1; cyc(5); pll_locked = 0; cyc(1); pll_locked = 1; cyc(75);
        // Short lock drop in RUN
        pll_locked = 0; cyc(2); pll_locked = 1; cyc(75);
        // Software reset: pulse, then held 10 cycles
        sw_rst = 1; cyc(1); sw_rst = 0; cyc(75);
        sw_rst = 1; cyc(10); sw_rst = 0; cyc(75);
        // sw_rst and lk fall landing on the same edge at cnt=20
        sw_rst = 1; cyc(1); sw_rst = 0;
        k = 0;
        while (m_rel != 18 && k < 300) begin cyc(1); k++; end
        check("wait_release", 32'(k < 300), 32'd1);
        pll_locked = 0; cyc(2);
        sw_rst = 1; cyc(1); sw_rst = 0; pll_locked = 1; cyc(75);
        // Random mix
        for (int s = 0; s < 60; s++) begin
            case ($urandom % 4)
                0: begin pll_locked = 0; cyc($urandom_range(1, 4)); pll_locked = 1; end
                1: begin sw_rst = 1; cyc($urandom_range(1, 6)); sw_rst = 0; end
                2: cyc($urandom_range(10, 80));
                default: begin
                    pll_locked = 0; cyc($urandom_range(1, 3));
                    pll_locked = 1; cyc($urandom_range(1, 9));
                    pll_locked = 0; cyc(1); pll_locked = 1;
                end
            endcase
            cyc($urandom_range(1, 20));
        end
        // 300 lock losses, each taken shortly after release begins
        repeat (300) begin pll_locked = 1; cyc(12); pll_locked = 0; cyc(4); end
        pll_locked = 1; cyc(2);
        check("llc_saturated", 32'(lock_lost_cnt), 32'd255);
        nrst = 0; cyc(1);
        check("llc_after_nrst", 32'(lock_lost_cnt), 32'd0);
        check("stage_after_nrst", 32'({stage_nrst, ready}), 32'd0);
        nrst = 1; cyc(80);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
